// File: rtl/beta_pipe_ctrl.sv
// beta_pipe_ctrl: hazard/stall/flush controller for a 3-register in-order pipeline.
// Optional performance counters are built when BETA_PIPE_PERF_EN is defined;
// otherwise stall_cnt_o and flush_cnt_o are constant zero.
module beta_pipe_ctrl #(
  parameter int unsigned FlushCycles = 1,
  parameter int unsigned CntWidth    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dec_valid_i,
  input  logic [4:0]          dec_rs1_addr_i,
  input  logic [4:0]          dec_rs2_addr_i,
  input  logic                dec_rs1_used_i,
  input  logic                dec_rs2_used_i,
  input  logic                exe_valid_i,
  input  logic [4:0]          exe_rd_addr_i,
  input  logic                exe_is_load_i,
  input  logic                exe_mem_req_i,
  input  logic                dmem_ready_i,
  input  logic                exe_busy_i,
  input  logic                exe_redirect_i,
  input  logic                imem_ready_i,
  input  logic                trap_i,
  output logic                pc_stall_o,
  output logic                if_dec_stall_o,
  output logic                if_dec_flush_o,
  output logic                dec_exe_stall_o,
  output logic                dec_exe_flush_o,
  output logic                exe_wb_stall_o,
  output logic                exe_wb_flush_o,
  output logic [CntWidth-1:0] stall_cnt_o,
  output logic [CntWidth-1:0] flush_cnt_o
);

  // Squash length beyond the redirect/trap cycle itself.
  localparam logic [1:0] FlushLoad = 2'(FlushCycles - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic backend;
  logic load_use;
  logic redirect;
  logic rs1_hit;
  logic rs2_hit;

  // Hazard detection terms.
  assign backend  = exe_valid_i & (exe_busy_i | (exe_mem_req_i & ~dmem_ready_i));
  assign rs1_hit  = dec_rs1_used_i & (dec_rs1_addr_i == exe_rd_addr_i);
  assign rs2_hit  = dec_rs2_used_i & (dec_rs2_addr_i == exe_rd_addr_i);
  assign load_use = dec_valid_i & exe_valid_i & exe_is_load_i &
                    (exe_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit);
  assign redirect = exe_valid_i & exe_redirect_i & ~backend;

  // State register; reset drops any mid-flush residue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority-ordered next-state and pipeline control decode.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pc_stall_o      = 1'b0;
    if_dec_stall_o  = 1'b0;
    if_dec_flush_o  = 1'b0;
    dec_exe_stall_o = 1'b0;
    dec_exe_flush_o = 1'b0;
    exe_wb_stall_o  = 1'b0;
    exe_wb_flush_o  = 1'b0;

    if (trap_i) begin
      if_dec_flush_o  = 1'b1;
      dec_exe_flush_o = 1'b1;
      exe_wb_flush_o  = 1'b1;
      state_d         = (FlushCycles > 1) ? FLUSH : RUN;
      cnt_d           = FlushLoad;
    end else if (redirect) begin
      if_dec_flush_o  = 1'b1;
      dec_exe_flush_o = 1'b1;
      state_d         = (FlushCycles > 1) ? FLUSH : RUN;
      cnt_d           = FlushLoad;
    end else if (backend) begin
      // Freeze the front end, bubble into writeback, hold flush progress.
      pc_stall_o      = 1'b1;
      if_dec_stall_o  = 1'b1;
      dec_exe_stall_o = 1'b1;
      exe_wb_flush_o  = 1'b1;
    end else if (load_use) begin
      // Load advances this cycle, so the hazard clears next cycle.
      pc_stall_o      = 1'b1;
      if_dec_stall_o  = 1'b1;
      dec_exe_flush_o = 1'b1;
    end else if (state_q == FLUSH) begin
      if_dec_flush_o = 1'b1;
      if (cnt_q <= 2'd1) begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (!imem_ready_i) begin
      pc_stall_o     = 1'b1;
      if_dec_flush_o = 1'b1;
    end
  end

`ifdef BETA_PIPE_PERF_EN
  logic [CntWidth-1:0] stall_cnt_q;
  logic [CntWidth-1:0] flush_cnt_q;
  logic                any_flush;

  assign any_flush = if_dec_flush_o | dec_exe_flush_o | exe_wb_flush_o;

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CntWidth'(1);
      end
      if (any_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CntWidth'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_beta_pipe_ctrl.sv
// Directed self-checking bench for beta_pipe_ctrl (FlushCycles = 3).
module tb_beta_pipe_ctrl;

  localparam int unsigned CntW = 32;
`ifdef BETA_PIPE_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // Output vector order: pc_stall, if_dec_stall, if_dec_flush, dec_exe_stall,
  // dec_exe_flush, exe_wb_stall, exe_wb_flush.
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] BE   = 7'b1101001;
  localparam logic [6:0] TRAP = 7'b0010101;
  localparam logic [6:0] RED  = 7'b0010100;
  localparam logic [6:0] FL   = 7'b0010000;
  localparam logic [6:0] IMEM = 7'b1010000;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_rs1_used, dec_rs2_used;
  logic [4:0] dec_rs1_addr, dec_rs2_addr, exe_rd_addr;
  logic exe_valid, exe_is_load, exe_mem_req, dmem_ready, exe_busy;
  logic exe_redirect, imem_ready, trap;
  logic pc_stall, if_dec_stall, if_dec_flush, dec_exe_stall, dec_exe_flush;
  logic exe_wb_stall, exe_wb_flush;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [6:0] obs;

  int total = 0;
  int bad = 0;
  logic [CntW-1:0] exp_stall = '0;
  logic [CntW-1:0] exp_flush = '0;

  always #5 clk = ~clk;

  assign obs = {pc_stall, if_dec_stall, if_dec_flush, dec_exe_stall,
                dec_exe_flush, exe_wb_stall, exe_wb_flush};

  beta_pipe_ctrl #(.FlushCycles(3), .CntWidth(CntW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .dec_valid_i    (dec_valid),
    .dec_rs1_addr_i (dec_rs1_addr),
    .dec_rs2_addr_i (dec_rs2_addr),
    .dec_rs1_used_i (dec_rs1_used),
    .dec_rs2_used_i (dec_rs2_used),
    .exe_valid_i    (exe_valid),
    .exe_rd_addr_i  (exe_rd_addr),
    .exe_is_load_i  (exe_is_load),
    .exe_mem_req_i  (exe_mem_req),
    .dmem_ready_i   (dmem_ready),
    .exe_busy_i     (exe_busy),
    .exe_redirect_i (exe_redirect),
    .imem_ready_i   (imem_ready),
    .trap_i         (trap),
    .pc_stall_o     (pc_stall),
    .if_dec_stall_o (if_dec_stall),
    .if_dec_flush_o (if_dec_flush),
    .dec_exe_stall_o(dec_exe_stall),
    .dec_exe_flush_o(dec_exe_flush),
    .exe_wb_stall_o (exe_wb_stall),
    .exe_wb_flush_o (exe_wb_flush),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // Quiet pipeline: nothing valid, memories ready.
  task automatic idle();
    dec_valid = 1'b0; dec_rs1_addr = 5'd0; dec_rs2_addr = 5'd0;
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
    exe_valid = 1'b0; exe_rd_addr = 5'd0; exe_is_load = 1'b0;
    exe_mem_req = 1'b0; dmem_ready = 1'b1; exe_busy = 1'b0;
    exe_redirect = 1'b0; imem_ready = 1'b1; trap = 1'b0;
  endtask

  // Load x<rd> in execute, decode reading x<rs1> through rs1.
  task automatic load_hazard(input logic [4:0] rd, input logic [4:0] rs1);
    dec_valid = 1'b1; dec_rs1_addr = rs1; dec_rs1_used = 1'b1;
    exe_valid = 1'b1; exe_rd_addr = rd; exe_is_load = 1'b1;
  endtask

  // Performance-counter reference model update for one completed cycle.
  task automatic tally(input logic [6:0] e);
    if (PerfEn && !rst) begin
      if (e[6]) exp_stall = exp_stall + 1;
      if (e[4] | e[2] | e[0]) exp_flush = exp_flush + 1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exps [0:2];
    exps = '{NONE, IMEM, NONE};
    for (int c = 0; c < 3; c++) begin
      idle();
      rst = (c < 2);
      if (c == 1) imem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== exps[c]) begin
        bad++; $display("FAIL reset c%0d outputs got=%b want=%b", c, obs, exps[c]);
      end
      total++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        bad++; $display("FAIL reset_cnt c%0d got=%0d/%0d want=%0d/%0d", c, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      tally(exps[c]);
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    logic [6:0] exps [0:5];
    exps = '{LU, NONE, LU, NONE, NONE, NONE};
    for (int c = 0; c < 6; c++) begin
      idle();
      case (c)
        0: load_hazard(5'd5, 5'd5);
        1: begin dec_valid = 1'b1; dec_rs1_addr = 5'd1; dec_rs1_used = 1'b1;
                 exe_valid = 1'b1; exe_rd_addr = 5'd3; end
        2: begin load_hazard(5'd7, 5'd2); dec_rs2_addr = 5'd7; dec_rs2_used = 1'b1; end
        3: begin load_hazard(5'd7, 5'd2); dec_rs2_addr = 5'd7; end
        4: load_hazard(5'd0, 5'd0);
        default: begin load_hazard(5'd9, 5'd9); dec_valid = 1'b0; end
      endcase
      @(negedge clk);
      total++;
      if (obs !== exps[c]) begin
        bad++; $display("FAIL load_use c%0d outputs got=%b want=%b", c, obs, exps[c]);
      end
      total++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        bad++; $display("FAIL load_use_cnt c%0d got=%0d/%0d want=%0d/%0d", c, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      tally(exps[c]);
      next_cycle();
    end
  endtask

  task automatic test_backend_then_load_use();
    logic [6:0] exps [0:4];
    exps = '{BE, BE, BE, LU, NONE};
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 4) begin
        load_hazard(5'd5, 5'd5);
        exe_mem_req = 1'b1;
        dmem_ready = (c == 3);
      end
      @(negedge clk);
      total++;
      if (obs !== exps[c]) begin
        bad++; $display("FAIL backend_lu c%0d outputs got=%b want=%b", c, obs, exps[c]);
      end
      total++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        bad++; $display("FAIL backend_lu_cnt c%0d got=%0d/%0d want=%0d/%0d", c, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      tally(exps[c]);
      next_cycle();
    end
  endtask

  task automatic test_redirect_flush();
    logic [6:0] exps [0:5];
    exps = '{NONE, RED, FL, FL, IMEM, NONE};
    for (int c = 0; c < 6; c++) begin
      idle();
      case (c)
        0: exe_redirect = 1'b1;
        1: begin exe_valid = 1'b1; exe_redirect = 1'b1; end
        2: imem_ready = 1'b0;
        4: imem_ready = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (obs !== exps[c]) begin
        bad++; $display("FAIL redirect c%0d outputs got=%b want=%b", c, obs, exps[c]);
      end
      total++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        bad++; $display("FAIL redirect_cnt c%0d got=%0d/%0d want=%0d/%0d", c, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      tally(exps[c]);
      next_cycle();
    end
  endtask

  task automatic test_redirect_busy();
    logic [6:0] exps [0:5];
    exps = '{BE, BE, RED, FL, FL, NONE};
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c < 3) begin
        exe_valid = 1'b1; exe_redirect = 1'b1; exe_busy = (c < 2);
      end
      @(negedge clk);
      total++;
      if (obs !== exps[c]) begin
        bad++; $display("FAIL redirect_busy c%0d outputs got=%b want=%b", c, obs, exps[c]);
      end
      total++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        bad++; $display("FAIL redirect_busy_cnt c%0d got=%0d/%0d want=%0d/%0d", c, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      tally(exps[c]);
      next_cycle();
    end
  endtask

  // Backend stall holds the flush countdown; redirect in flush reloads it.
  task automatic test_flush_hold_reload();
    logic [6:0] exps [0:8];
    exps = '{RED, BE, FL, RED, FL, FL, NONE, NONE, NONE};
    for (int c = 0; c < 9; c++) begin
      idle();
      case (c)
        0, 3: begin exe_valid = 1'b1; exe_redirect = 1'b1; end
        1: begin exe_valid = 1'b1; exe_busy = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (obs !== exps[c]) begin
        bad++; $display("FAIL flush_hold c%0d outputs got=%b want=%b", c, obs, exps[c]);
      end
      total++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        bad++; $display("FAIL flush_hold_cnt c%0d got=%0d/%0d want=%0d/%0d", c, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      tally(exps[c]);
      next_cycle();
    end
  endtask

  task automatic test_trap_reset();
    logic [6:0] exps [0:6];
    exps = '{TRAP, FL, TRAP, NONE, NONE, IMEM, NONE};
    for (int c = 0; c < 7; c++) begin
      idle();
      rst = 1'b0;
      case (c)
        0: begin load_hazard(5'd4, 5'd4); exe_busy = 1'b1; trap = 1'b1; end
        2: trap = 1'b1;
        3: begin rst = 1'b1; exp_stall = '0; exp_flush = '0; end
        5: imem_ready = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      total++;
      if (obs !== exps[c]) begin
        bad++; $display("FAIL trap_reset c%0d outputs got=%b want=%b", c, obs, exps[c]);
      end
      total++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        bad++; $display("FAIL trap_reset_cnt c%0d got=%0d/%0d want=%0d/%0d", c, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
      tally(exps[c]);
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_backend_then_load_use();
    test_redirect_flush();
    test_redirect_busy();
    test_flush_hold_reload();
    test_trap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beta_pipe_ctrl.md
BETA_PIPE_CTRL -- requirements
Module: beta_pipe_ctrl

Interface
REQ-001 Parameter FlushCycles, default 1, is the number of cycles the fetch/decode register is squashed after a redirect; legal range 1..4.
REQ-002 Parameter CntWidth, default 32, is the width of the performance counters.
REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 dec_valid_i  in  1  decode stage holds a valid instruction.
REQ-006 dec_rs1_addr_i, dec_rs2_addr_i  in  5 each  decode source register addresses.
REQ-007 dec_rs1_used_i, dec_rs2_used_i  in  1 each  the matching source register is actually read.
REQ-008 exe_valid_i  in  1  execute stage holds a valid instruction (dec_exe register output).
REQ-009 exe_rd_addr_i  in  5  execute destination register.
REQ-010 exe_is_load_i  in  1  execute instruction is a load.
REQ-011 exe_mem_req_i  in  1  execute issues a data-memory access.
REQ-012 dmem_ready_i  in  1  data memory accepts/completes this cycle.
REQ-013 exe_busy_i  in  1  multi-cycle execute unit not done.
REQ-014 exe_redirect_i  in  1  taken branch/jump resolved in execute.
REQ-015 imem_ready_i  in  1  instruction memory delivers this cycle.
REQ-016 trap_i  in  1  exception/interrupt entry; kill all in-flight instructions.
REQ-017 pc_stall_o  out  1  hold the PC.
REQ-018 if_dec_stall_o, if_dec_flush_o  out  1 each  fetch/decode register control.
REQ-019 dec_exe_stall_o, dec_exe_flush_o  out  1 each  decode/execute register control.
REQ-020 exe_wb_stall_o, exe_wb_flush_o  out  1 each  execute/writeback register control.
REQ-021 stall_cnt_o, flush_cnt_o  out  CntWidth each  performance counters (REQ-036).

Function
REQ-022 The FSM shall have two states: RUN and FLUSH; FLUSH holds a down-counter cnt_q (2 bits).
REQ-023 Derived terms:
- backend = exe_valid_i & (exe_busy_i | (exe_mem_req_i & ~dmem_ready_i)).
- load_use = dec_valid_i & exe_valid_i & exe_is_load_i & exe_rd_addr_i != 0 & ((dec_rs1_used_i & rs1 == rd) | (dec_rs2_used_i & rs2 == rd)).
- redirect = exe_valid_i & exe_redirect_i & ~backend.
REQ-024 All outputs shall be combinational from the inputs and state; the first matching priority rule applies, and unlisted outputs are 0.
REQ-025 Priority 1, trap_i: assert all three flush outputs; no stall output; next state FLUSH with cnt_q = FlushCycles-1, or RUN if FlushCycles = 1.
REQ-026 Priority 2, redirect: assert if_dec_flush_o and dec_exe_flush_o; next state as in REQ-025.
REQ-027 Priority 3, backend: assert pc_stall_o, if_dec_stall_o, dec_exe_stall_o and exe_wb_flush_o (bubble into writeback); state unchanged; in FLUSH, cnt_q is held.
REQ-028 Priority 4, load_use: assert pc_stall_o, if_dec_stall_o and dec_exe_flush_o; the stall lasts exactly one cycle because the load advances.
REQ-029 Priority 5, FLUSH state: assert if_dec_flush_o; decrement cnt_q; go to RUN when cnt_q = 0 at the clock edge.
REQ-030 Priority 6, ~imem_ready_i: assert pc_stall_o and if_dec_flush_o.
REQ-031 Otherwise (RUN, no hazard): all outputs 0.
REQ-032 A stall and a flush shall never be asserted together on the same register.
REQ-033 Register 0 shall never cause a load-use stall.
REQ-034 A new trap or redirect while in FLUSH shall reload cnt_q.

Reset
REQ-035 While rst_i = 1: state = RUN, cnt_q = 0, counters = 0; outputs follow REQ-024 through REQ-031 for state RUN; no mid-flush residue survives reset.

Configuration
REQ-036 Macro BETA_PIPE_PERF_EN.
- Defined: stall_cnt_o counts cycles with pc_stall_o = 1; flush_cnt_o counts cycles with any flush output = 1; both saturate at all-ones.
- Undefined: no counter registers; both ports are constant 0.

Verification
REQ-037 Load x5 in execute, decode add reading rs1 = x5 -> one cycle of pc_stall_o = if_dec_stall_o = dec_exe_flush_o = 1, then all 0.
REQ-038 Load to x0 with rs1 = x0 in decode -> no stall.
REQ-039 exe_mem_req_i = 1, dmem_ready_i = 0 for 3 cycles, with load_use also true -> 3 cycles of backend pattern (REQ-027), then 1 cycle of load-use pattern (REQ-028).
REQ-040 FlushCycles = 3, redirect pulse -> cycle 0: if_dec_flush_o = dec_exe_flush_o = 1; cycles 1-2: if_dec_flush_o only; cycle 3: RUN.
REQ-041 Redirect and exe_busy_i together -> backend pattern only; redirect taken in the first cycle exe_busy_i = 0.
REQ-042 trap_i during FLUSH, then rst_i asserted mid-flush -> all flush outputs on the trap cycle; after reset, RUN and counters = 0; with BETA_PIPE_PERF_EN, counters match counted cycles before reset.
